// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO write-side logic.
//   arb_state_t : write arbiter FSM encoding (2 bits)
//   FIFO_DW     : default FIFO data width
package fifo_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GAP   = 2'd2,
        ARB_STALL = 2'd3
    } arb_state_t;

    localparam int FIFO_DW = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector
//   last   : index of the previous winner; the scan starts at last+1
//   onehot : one-hot winner (0 when no request)
//   idx    : winner index (0 when no request)
//   valid  : at least one request is set
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Scan last+1 .. last+NREQ (mod NREQ); the previous winner is checked
    // last, so it only wins again when nobody else is asking.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid && req[(int'(last) + k) % NREQ]) begin
                valid                             = 1'b1;
                idx                               = IW'((int'(last) + k) % NREQ);
                onehot[(int'(last) + k) % NREQ]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the single FIFO write port
// between NREQ producers.
//   clk, rst_edge : clock, asynchronous active-high reset
//   req           : per-producer level request, held until ack
//   wr_data_in    : flattened producer data, slice i = [i*DW +: DW]
//   fifo_full     : FIFO full flag (back-pressure)
//   wr_edge       : one-cycle write pulse to the FIFO
//   wr_data       : data for the current write (granted slice)
//   grant         : registered one-hot grant, 0 when idle
//   ack           : one-cycle pulse to the producer whose word was written
//   busy          : arbiter not in IDLE
//   stall_cnt     : saturating count of cycles stalled on a full FIFO
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = FIFO_DW,
    parameter int SCW  = 8
) (
    input  logic              clk,
    input  logic              rst_edge,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] wr_data_in,
    input  logic              fifo_full,
    output logic              wr_edge,
    output logic [DW-1:0]     wr_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [SCW-1:0]    stall_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    // last resets to NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            last      <= IW'(NREQ - 1);
            stall_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick_oh;
                        last  <= pick_idx;
                        state <= fifo_full ? ARB_STALL : ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // Full rising in the issue cycle keeps the grant and
                    // retries from STALL; otherwise the word was written.
                    if (fifo_full) begin
                        state <= ARB_STALL;
                    end else begin
                        state <= ARB_GAP;
                        grant <= '0;
                    end
                end
                ARB_GAP: begin
                    state <= ARB_IDLE;
                end
                ARB_STALL: begin
                    // Only cycles actually blocked by full are counted.
                    if (fifo_full) begin
                        if (stall_cnt != '1)
                            stall_cnt <= stall_cnt + SCW'(1);
                    end else begin
                        state <= ARB_ISSUE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Gating on fifo_full here guarantees no write is ever issued into a
    // full FIFO, even when full rises during the issue cycle.
    assign wr_edge = (state == ARB_ISSUE) && !fifo_full;
    assign ack     = wr_edge ? grant : '0;
    assign busy    = (state != ARB_IDLE);

    // grant is one-hot or zero, so an OR-mux suffices.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i])
                wr_data = wr_data | wr_data_in[i*DW +: DW];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_edge;
    logic [1:0]  req;
    logic [15:0] wr_data_in;
    logic        fifo_full;

    logic        wr_edge;
    logic [7:0]  wr_data;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic        busy;
    logic [7:0]  stall_cnt;

    logic        wr_edge4;
    logic [7:0]  wr_data4;
    logic [1:0]  grant4;
    logic [1:0]  ack4;
    logic        busy4;
    logic [3:0]  stall_cnt4;

    int total;
    int bad;

    fifo_wr_arbiter #(.NREQ(2), .DW(8), .SCW(8)) dut (
        .clk(clk), .rst_edge(rst_edge), .req(req), .wr_data_in(wr_data_in),
        .fifo_full(fifo_full), .wr_edge(wr_edge), .wr_data(wr_data),
        .grant(grant), .ack(ack), .busy(busy), .stall_cnt(stall_cnt)
    );

    fifo_wr_arbiter #(.NREQ(2), .DW(8), .SCW(4)) dut4 (
        .clk(clk), .rst_edge(rst_edge), .req(req), .wr_data_in(wr_data_in),
        .fifo_full(fifo_full), .wr_edge(wr_edge4), .wr_data(wr_data4),
        .grant(grant4), .ack(ack4), .busy(busy4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs may be changed and outputs sampled afterwards
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        req = 2'b00; fifo_full = 1'b0;
        rst_edge = 1'b1;
        cyc; cyc;
        rst_edge = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_edge = 1'b1; req = 2'b00; fifo_full = 1'b0; wr_data_in = 16'h0000;
        cyc; cyc;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (wr_edge !== 1'b0) begin bad++; $display("FAIL reset_wr_edge got=%b want=0", wr_edge); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", wr_data); end
        total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        rst_edge = 1'b0;
        #1;
    endtask

    task automatic test_single;
        req = 2'b01; wr_data_in = 16'h00A5; fifo_full = 1'b0;
        cyc;  // ISSUE
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", grant); end
        total++; if (wr_edge !== 1'b1) begin bad++; $display("FAIL single_wr_edge got=%b want=1", wr_edge); end
        total++; if (wr_data !== 8'hA5) begin bad++; $display("FAIL single_wr_data got=%h want=a5", wr_data); end
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL single_ack got=%b want=01", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        req = 2'b00;
        cyc;  // GAP
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_gap_grant got=%b want=00", grant); end
        total++; if (wr_edge !== 1'b0) begin bad++; $display("FAIL single_gap_wr_edge got=%b want=0", wr_edge); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got=%b want=1", busy); end
        cyc;  // IDLE
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_fairness;
        logic [1:0] exp_ack;
        logic       exp_we;
        logic [7:0] exp_d;
        int         writes;
        do_reset;
        writes = 0;
        req = 2'b11; wr_data_in = 16'h2211;
        for (int c = 1; c <= 12; c++) begin
            cyc;
            exp_we  = (c % 3 == 1);
            exp_ack = !exp_we ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            exp_d   = (exp_ack == 2'b10) ? 8'h22 : (exp_ack == 2'b01 ? 8'h11 : 8'h00);
            if (wr_edge === 1'b1) writes++;
            total++; if (wr_edge !== exp_we) begin bad++; $display("FAIL fair_wr_edge c=%0d got=%b want=%b", c, wr_edge, exp_we); end
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL fair_ack c=%0d got=%b want=%b", c, ack, exp_ack); end
            if (exp_we) begin
                total++; if (wr_data !== exp_d) begin bad++; $display("FAIL fair_wr_data c=%0d got=%h want=%h", c, wr_data, exp_d); end
            end
        end
        req = 2'b00;
        total++; if (writes != 4) begin bad++; $display("FAIL fair_write_count got=%0d want=4", writes); end
        cyc; cyc;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_full_stall;
        req = 2'b10; fifo_full = 1'b1; wr_data_in = 16'h3C00;
        cyc;  // STALL
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL stall_grant got=%b want=10", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        for (int k = 1; k <= 5; k++) begin
            cyc;
            total++; if (stall_cnt !== 8'(k)) begin bad++; $display("FAIL stall_cnt k=%0d got=%0d want=%0d", k, stall_cnt, k); end
            total++; if (wr_edge !== 1'b0 || grant !== 2'b10) begin bad++; $display("FAIL stall_hold k=%0d got we=%b g=%b want we=0 g=10", k, wr_edge, grant); end
        end
        fifo_full = 1'b0;
        cyc;  // ISSUE
        total++; if (ack !== 2'b10) begin bad++; $display("FAIL stall_release_ack got=%b want=10", ack); end
        total++; if (wr_data !== 8'h3C) begin bad++; $display("FAIL stall_release_data got=%h want=3c", wr_data); end
        total++; if (stall_cnt !== 8'd5) begin bad++; $display("FAIL stall_frozen got=%0d want=5", stall_cnt); end
        req = 2'b00;
        cyc; cyc;
    endtask

    task automatic test_full_during_issue;
        req = 2'b01; wr_data_in = 16'h005A; fifo_full = 1'b0;
        cyc;  // ISSUE
        fifo_full = 1'b1;
        #1;
        total++; if (wr_edge !== 1'b0) begin bad++; $display("FAIL rise_wr_edge got=%b want=0", wr_edge); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL rise_ack got=%b want=00", ack); end
        cyc;  // STALL
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rise_grant_kept got=%b want=01", grant); end
        total++; if (stall_cnt !== 8'd5) begin bad++; $display("FAIL rise_cnt0 got=%0d want=5", stall_cnt); end
        cyc;
        total++; if (stall_cnt !== 8'd6) begin bad++; $display("FAIL rise_cnt1 got=%0d want=6", stall_cnt); end
        fifo_full = 1'b0;
        #1;
        total++; if (wr_edge !== 1'b0) begin bad++; $display("FAIL rise_stall_we got=%b want=0", wr_edge); end
        cyc;  // ISSUE
        total++; if (wr_edge !== 1'b1 || ack !== 2'b01) begin bad++; $display("FAIL rise_complete got we=%b ack=%b want we=1 ack=01", wr_edge, ack); end
        total++; if (wr_data !== 8'h5A) begin bad++; $display("FAIL rise_data got=%h want=5a", wr_data); end
        req = 2'b00;
        cyc; cyc;
    endtask

    task automatic test_reset_mid_stall;
        // last=0 here, so requester 1 is granted first
        req = 2'b11; fifo_full = 1'b1; wr_data_in = 16'h7733;
        cyc;  // STALL
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL midrst_pre_grant got=%b want=10", grant); end
        cyc;
        #1 rst_edge = 1'b1;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL midrst_grant got=%b want=00", grant); end
        total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", stall_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL midrst_ack got=%b want=00", ack); end
        cyc;
        total++; if (grant !== 2'b00 || ack !== 2'b00) begin bad++; $display("FAIL midrst_held got g=%b ack=%b want 00 00", grant, ack); end
        rst_edge = 1'b0; fifo_full = 1'b0;
        #1;
        cyc;  // ISSUE, requester 0 first
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL midrst_first_ack got=%b want=01", ack); end
        total++; if (wr_data !== 8'h33) begin bad++; $display("FAIL midrst_first_data got=%h want=33", wr_data); end
        req = 2'b00;
        cyc; cyc;
    endtask

    task automatic test_saturation;
        do_reset;
        req = 2'b01; fifo_full = 1'b1; wr_data_in = 16'h00C3;
        cyc;  // STALL
        for (int k = 1; k <= 20; k++) begin
            cyc;
            total++; if (stall_cnt4 !== 4'((k > 15) ? 15 : k)) begin bad++; $display("FAIL sat_cnt4 k=%0d got=%0d want=%0d", k, stall_cnt4, (k > 15) ? 15 : k); end
        end
        total++; if (stall_cnt !== 8'd20) begin bad++; $display("FAIL sat_cnt8 got=%0d want=20", stall_cnt); end
        fifo_full = 1'b0;
        cyc;  // ISSUE
        total++; if (ack4 !== 2'b01 || wr_edge4 !== 1'b1) begin bad++; $display("FAIL sat_issue got ack=%b we=%b want 01 1", ack4, wr_edge4); end
        total++; if (wr_data4 !== 8'hC3 || grant4 !== 2'b01) begin bad++; $display("FAIL sat_data got d=%h g=%b want c3 01", wr_data4, grant4); end
        total++; if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_frozen got=%0d want=15", stall_cnt4); end
        req = 2'b00;
        cyc; cyc;
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL sat_end_busy got=%b want=0", busy4); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_edge = 1'b1; req = 2'b00; fifo_full = 1'b0; wr_data_in = 16'h0000;
        test_reset;
        test_single;
        test_fairness;
        test_full_stall;
        test_full_during_issue;
        test_reset_mid_stall;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
